mesh_result_checker: RTL and testbench

//  Synthesisable self-checker for the sorting mesh; successor to the bench-only output compare.

---
 rtl/mesh_result_checker_if.sv | 30 +++
 rtl/mesh_result_checker.sv | 169 ++++++++++++++++
 tb/tb_mesh_result_checker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mesh_result_checker_if.sv
// Bus between the sorting-mesh result checker and its environment.
// master: the checker (issues PE reads, reports status).
// slave : the mesh read port plus the host that pulses start and reads the report.
interface mesh_result_checker_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH + 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_en;
  logic [WORD_W-1:0]     rd_word;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH:0]   err_count;
  logic [ADDR_WIDTH-1:0] first_err;
  logic [WORD_W-1:0]     first_word;

  modport master (
    input  start, rd_word,
    output rd_idx, rd_en, busy, done, pass, err_count, first_err, first_word
  );

  modport slave (
    output start, rd_word,
    input  rd_idx, rd_en, busy, done, pass, err_count, first_err, first_word
  );
endinterface

// File: rtl/mesh_result_checker.sv
// Synthesisable self-checker for the sorting mesh.
// After start it waits SORT_CYCLES cycles, reads every PE result word once
// (read latency 1), compares it with the EXPECT_MODE pattern and reports
// done/pass, a saturating mismatch count and the first failing index.
// Optional feature: define MESH_CHECK_CAPTURE_EN to latch the first bad
// word into first_word; otherwise first_word is tied to zero.
module mesh_result_checker #(
  parameter int N           = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int SORT_CYCLES = 112,
  parameter int EXPECT_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mesh_result_checker_if.master bus
);

  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int WAIT_W = $clog2(SORT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]      scan_q, scan_d;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] idx_p1;
  logic [CNT_W-1:0]      err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [WORD_W-1:0]     exp_word;
  logic                  mismatch;
  logic                  restart;
`ifdef MESH_CHECK_CAPTURE_EN
  logic [WORD_W-1:0]     first_word_q, first_word_d;
`endif

  // Expected result word of PE k: {0, k, E}, E reverse or identity pattern.
  function automatic logic [WORD_W-1:0] expected_word(input logic [ADDR_WIDTH-1:0] k);
    logic [DATA_WIDTH-1:0] e;
    if (EXPECT_MODE == 0) e = DATA_WIDTH'(N - 1 - int'(k));
    else                  e = DATA_WIDTH'(k);
    return {1'b0, k, e};
  endfunction

  // Mismatch counter increment that sticks at N.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(N)) return c;
    else                return c + 1'b1;
  endfunction

  assign restart = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // Stage p0: sequence controller (wait count, index issue, drain).
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    scan_d  = scan_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(SORT_CYCLES - 1)) begin
          state_d = S_SCAN;
          scan_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_q == CNT_W'(N - 1)) state_d = S_DRAIN;
        else                         scan_d  = scan_q + 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1: rd_word for the index issued last cycle is compared here.
  assign exp_word = expected_word(idx_p1);
  assign mismatch = vld_p1 && (bus.rd_word != exp_word);

  // Report bookkeeping: clear on restart, count/latch on mismatch, finalise in DRAIN.
  always_comb begin
    err_d       = err_q;
    first_err_d = first_err_q;
    done_d      = done_q;
    pass_d      = pass_q;
`ifdef MESH_CHECK_CAPTURE_EN
    first_word_d = first_word_q;
`endif
    if (restart) begin
      err_d       = '0;
      first_err_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
`ifdef MESH_CHECK_CAPTURE_EN
      first_word_d = '0;
`endif
    end else if (mismatch) begin
      if (err_q == '0) begin
        first_err_d = idx_p1;
`ifdef MESH_CHECK_CAPTURE_EN
        first_word_d = bus.rd_word;
`endif
      end
      err_d = sat_inc(err_q);
    end
    if (state_q == S_DRAIN) begin
      done_d = 1'b1;
      pass_d = (err_d == '0);
    end
  end

  // Control and report registers; reset aborts a run with no report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      scan_q      <= '0;
      vld_p1      <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      scan_q      <= scan_d;
      vld_p1      <= (state_q == S_SCAN);
      err_q       <= err_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Index delayed one stage to line up with the returning rd_word.
  always_ff @(posedge clk) begin
    idx_p1 <= scan_q[ADDR_WIDTH-1:0];
  end

`ifdef MESH_CHECK_CAPTURE_EN
  // Captured first bad word, sticky for the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) first_word_q <= '0;
    else     first_word_q <= first_word_d;
  end
  assign bus.first_word = first_word_q;
`else
  assign bus.first_word = '0;
`endif

  assign bus.rd_idx    = scan_q[ADDR_WIDTH-1:0];
  assign bus.rd_en     = (state_q == S_SCAN);
  assign bus.busy      = (state_q == S_WAIT) || (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.first_err = first_err_q;

endmodule

// File: tb/tb_mesh_result_checker.sv
// Bench for mesh_result_checker: two instances (N=256/SORT_CYCLES=112/reverse
// and N=4/SORT_CYCLES=1/identity) fed by small PE read-port models.
module tb_mesh_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mesh_result_checker_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ifa ();
  mesh_result_checker_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ifb ();

  mesh_result_checker #(.N(256), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SORT_CYCLES(112), .EXPECT_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mesh_result_checker #(.N(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SORT_CYCLES(1), .EXPECT_MODE(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;
  bit fault_a = 1'b0;  // PE 17 returns data 0, PE 200 sets the top bit
  bit bmode   = 1'b1;  // 1: instance B's PEs return identity data, 0: reverse

  typedef struct { int idx; int cyc; } rd_exp_t;
  typedef struct { int done_cyc; bit pass; int err; int first; logic [40:0] fword; } res_t;
  rd_exp_t rd_q[$];
  res_t    res_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // PE read-port model: what each mesh PE actually returns.
  function automatic logic [40:0] pe_word(input int sel, input logic [7:0] k);
    logic [31:0] d;
    logic [40:0] w;
    if (sel == 0) begin
      d = 32'(255 - int'(k));
      if (fault_a && k == 8'd17) d = 32'd0;
    end else begin
      d = bmode ? 32'(k) : 32'(3 - int'(k));
    end
    w = {1'b0, k, d};
    if (sel == 0 && fault_a && k == 8'd200) w[40] = 1'b1;
    return w;
  endfunction

  // What a correctly sorted mesh holds: A reverse pattern, B identity.
  function automatic logic [40:0] good_word(input int sel, input logic [7:0] k);
    if (sel == 0) return {1'b0, k, 32'(255 - int'(k))};
    return {1'b0, k, 32'(k)};
  endfunction

  always @(posedge clk) begin
    if (ifa.rd_en) ifa.rd_word <= pe_word(0, ifa.rd_idx);
    if (ifb.rd_en) ifb.rd_word <= pe_word(1, ifb.rd_idx);
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v;
    else          ifb.start = v;
  endtask

  task automatic sample(input int sel, output logic en, output logic [7:0] idx,
                        output logic dn, output logic ps, output logic bsy,
                        output logic [8:0] ec, output logic [7:0] fe, output logic [40:0] fw);
    if (sel == 0) begin
      en = ifa.rd_en; idx = ifa.rd_idx; dn = ifa.done; ps = ifa.pass; bsy = ifa.busy;
      ec = ifa.err_count; fe = ifa.first_err; fw = ifa.first_word;
    end else begin
      en = ifb.rd_en; idx = ifb.rd_idx; dn = ifb.done; ps = ifb.pass; bsy = ifb.busy;
      ec = ifb.err_count; fe = ifb.first_err; fw = ifb.first_word;
    end
  endtask

  // One check run; restart_at >= 0 pulses start again in that cycle (must be ignored).
  task automatic run(input int sel, input int restart_at);
    int n, s, cyc, done_cyc, ec_m, fe_m;
    logic [40:0] w, fw_m;
    logic en, dn, ps, bsy;
    logic [7:0] idx, fe;
    logic [8:0] ec;
    logic [40:0] fw;
    rd_exp_t re;
    res_t r;
    n = (sel == 0) ? 256 : 4;
    s = (sel == 0) ? 112 : 1;
    rd_q.delete();
    for (int k = 0; k < n; k++) rd_q.push_back('{idx: k, cyc: s + 1 + k});
    ec_m = 0; fe_m = 0; fw_m = '0;
    for (int k = 0; k < n; k++) begin
      w = pe_word(sel, 8'(k));
      if (w !== good_word(sel, 8'(k))) begin
        if (ec_m == 0) begin fe_m = k; fw_m = w; end
        if (ec_m < n) ec_m++;
      end
    end
`ifndef MESH_CHECK_CAPTURE_EN
    fw_m = '0;
`endif
    res_q.push_back('{done_cyc: s + n + 2, pass: (ec_m == 0), err: ec_m, first: fe_m, fword: fw_m});

    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    cyc = 1;
    done_cyc = -1;
    sample(sel, en, idx, dn, ps, bsy, ec, fe, fw);
    chk("start_clears_done", {63'd0, dn}, 64'd0);
    chk("start_clears_err", {55'd0, ec}, 64'd0);
    chk("busy_in_wait", {63'd0, bsy}, 64'd1);
    while (cyc < s + n + 20) begin
      sample(sel, en, idx, dn, ps, bsy, ec, fe, fw);
      if (en) begin
        if (rd_q.size() == 0) chk("extra_rd_en", 64'd1, 64'd0);
        else begin
          re = rd_q.pop_front();
          chk("rd_idx", {56'd0, idx}, 64'(re.idx));
          chk("rd_en_cycle", 64'(cyc), 64'(re.cyc));
        end
      end
      if (dn) begin done_cyc = cyc; break; end
      set_start(sel, (cyc == restart_at) ? 1'b1 : 1'b0);
      @(negedge clk);
      cyc++;
    end
    set_start(sel, 1'b0);
    chk("reads_missing", 64'(rd_q.size()), 64'd0);
    r = res_q.pop_front();
    sample(sel, en, idx, dn, ps, bsy, ec, fe, fw);
    chk("done_cycle", 64'(done_cyc), 64'(r.done_cyc));
    chk("pass", {63'd0, ps}, {63'd0, r.pass});
    chk("err_count", {55'd0, ec}, 64'(r.err));
    chk("first_err", {56'd0, fe}, 64'(r.first));
    chk("first_word", {23'd0, fw}, {23'd0, r.fword});
    chk("busy_at_done", {63'd0, bsy}, 64'd0);
    repeat (3) @(negedge clk);
    sample(sel, en, idx, dn, ps, bsy, ec, fe, fw);
    chk("done_held", {63'd0, dn}, 64'd1);
    chk("pass_held", {63'd0, ps}, {63'd0, r.pass});
    chk("no_rd_en_in_done", {63'd0, en}, 64'd0);
  endtask

  initial begin
    int cnt;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifa.rd_word = '0;
    ifb.rd_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, ifa.busy}, 64'd0);
    chk("rst_done", {63'd0, ifa.done}, 64'd0);
    chk("rst_pass", {63'd0, ifa.pass}, 64'd0);
    chk("rst_err", {55'd0, ifa.err_count}, 64'd0);
    chk("rst_rd_en", {63'd0, ifb.rd_en}, 64'd0);
    chk("rst_rd_idx", {56'd0, ifb.rd_idx}, 64'd0);
    rst = 1'b0;

    // Reset in the middle of the wait phase aborts the run.
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (49) @(negedge clk);
    chk("busy_cycle50", {63'd0, ifa.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, ifa.busy}, 64'd0);
    chk("abort_done", {63'd0, ifa.done}, 64'd0);
    chk("abort_err", {55'd0, ifa.err_count}, 64'd0);
    chk("abort_first_err", {56'd0, ifa.first_err}, 64'd0);
    chk("abort_first_word", {23'd0, ifa.first_word}, 64'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (ifa.rd_en || ifa.busy || ifa.done) cnt++;
    end
    chk("idle_after_abort", 64'(cnt), 64'd0);

    // Clean sorted mesh, then faulty PEs with a stray start during SCAN,
    // then a rerun from DONE, then clean again.
    fault_a = 1'b0; run(0, -1);
    fault_a = 1'b1; run(0, 112 + 10);
    run(0, -1);
    fault_a = 1'b0; run(0, -1);

    // Small mesh: correct identity data, then reverse data (every PE wrong).
    bmode = 1'b1; run(1, -1);
    bmode = 1'b0; run(1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
